// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM states and counter sizing shared by the serial adder slice
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result buses
interface serial_adder_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIn;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             COut;
  modport master(output start, A, B, CIn, input busy, done, Sum, COut);
  modport slave(input start, A, B, CIn, output busy, done, Sum, COut);
endinterface

// File: rtl/serial_adder_fulladd.sv
// fulladd: single-bit full adder cell
module fulladd (
  input  logic A,
  input  logic B,
  input  logic CIn,
  output logic Sum,
  output logic COut
);
  assign Sum  = A ^ B ^ CIn;
  assign COut = (A & B) | (CIn & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial A+B+CIn through one fulladd cell, one bit per clock
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_bits(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sum, r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_busy, r_done;
  logic             w_s, w_c;
  logic [WIDTH:0]   w_cat;
  fulladd u_fa (.A(r_a[0]), .B(r_b[0]), .CIn(r_carry), .Sum(w_s), .COut(w_c));
  // Concatenate-then-drop keeps the shift legal when WIDTH is 1
  assign w_cat = {w_s, r_sum};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.CIn;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= w_cat[WIDTH:1];
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_res   <= w_cat[WIDTH:1];
            r_cout  <= w_c;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.Sum  = r_res;
  assign bus.COut = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the serial adder at WIDTH 4, 1 and 8
module tb_serial_adder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  serial_adder_if #(.WIDTH(4)) b4 ();
  serial_adder_if #(.WIDTH(1)) b1 ();
  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=4 op; lat counts edges from acceptance (edge 0) until done is seen
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                     output logic [3:0] s, output logic co, output int lat, output int bcnt,
                     output logic busy_at_done);
    b4.A = a; b4.B = b; b4.CIn = c; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    lat = 1; bcnt = 0;
    while (!b4.done && lat < 20) begin
      if (b4.busy) bcnt++;
      tick();
      lat++;
    end
    s = b4.Sum; co = b4.COut; busy_at_done = b4.busy;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.Sum !== 4'd0 || b4.COut !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b Sum=%0d COut=%b required 0 0 0 0", b4.busy, b4.done, b4.Sum, b4.COut);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] s; logic co, bd; int lat, bc;
    op4(4'd3, 4'd5, 1'b0, s, co, lat, bc, bd);
    checks++;
    if (s !== 4'd8 || co !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: got %b/%0d required 0/8", co, s);
    end
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL basic_latency: got %0d required 5", lat);
    end
    checks++;
    if (bc !== 4) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d required 4", bc);
    end
    checks++;
    if (bd !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_in_done: got %b required 0", bd);
    end
    checks++;
    if (b4.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got %b required 0", b4.done);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] s; logic co, bd; int lat, bc;
    op4(4'd15, 4'd1, 1'b0, s, co, lat, bc, bd);
    checks++;
    if (s !== 4'd0 || co !== 1'b1) begin
      failures++;
      $display("FAIL wrap_15_1: got %b/%0d required 1/0", co, s);
    end
    op4(4'd15, 4'd15, 1'b1, s, co, lat, bc, bd);
    checks++;
    if (s !== 4'd15 || co !== 1'b1) begin
      failures++;
      $display("FAIL wrap_15_15_1: got %b/%0d required 1/15", co, s);
    end
  endtask

  task automatic test_ignored_start();
    int nd = 0;
    logic [3:0] s = 4'hx;
    logic co = 1'bx;
    logic [7:0] bv;
    b4.A = 4'd2; b4.B = 4'd2; b4.CIn = 1'b0; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    b4.A = 4'd7; b4.B = 4'd7; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (b4.done) begin nd++; s = b4.Sum; co = b4.COut; end
      tick();
    end
    checks++;
    if (nd !== 1) begin
      failures++;
      $display("FAIL ignored_start_done_count: got %0d required 1", nd);
    end
    checks++;
    if (s !== 4'd4 || co !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start_sum: got %b/%0d required 0/4", co, s);
    end
    b4.A = 4'd1; b4.B = 4'd1; b4.start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bv[i] = b4.busy;
      tick();
    end
    b4.start = 1'b0;
    checks++;
    if (bv !== 8'hCF) begin
      failures++;
      $display("FAIL held_start_busy_pattern: got %b required 11001111", bv);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] s; logic co, bd; int lat, bc;
    b4.A = 4'd9; b4.B = 4'd6; b4.CIn = 1'b0; b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.Sum !== 4'd0 || b4.COut !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b Sum=%0d COut=%b required 0 0 0 0", b4.busy, b4.done, b4.Sum, b4.COut);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (b4.done !== 1'b0 || b4.Sum !== 4'd0) begin
        failures++;
        $display("FAIL reset_mid_no_partial: done=%b Sum=%0d required 0 0", b4.done, b4.Sum);
      end
      tick();
    end
    op4(4'd1, 4'd1, 1'b0, s, co, lat, bc, bd);
    checks++;
    if (s !== 4'd2 || co !== 1'b0) begin
      failures++;
      $display("FAIL after_reset_op: got %b/%0d required 0/2", co, s);
    end
  endtask

  task automatic test_hold();
    logic [3:0] s; logic co, bd; int lat, bc;
    op4(4'd3, 4'd5, 1'b0, s, co, lat, bc, bd);
    for (int i = 0; i < 10; i++) begin
      b4.A = 4'(i * 3 + 1); b4.B = 4'(15 - i); b4.CIn = i[0];
      tick();
      checks++;
      if (b4.Sum !== 4'd8 || b4.COut !== 1'b0 || b4.done !== 1'b0) begin
        failures++;
        $display("FAIL hold: Sum=%0d COut=%b done=%b required 8 0 0", b4.Sum, b4.COut, b4.done);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] s; logic co, bd; int lat, bc;
    logic [4:0] ref_v;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          op4(4'(a), 4'(b), c[0], s, co, lat, bc, bd);
          ref_v = 5'(a + b + c);
          checks++;
          if ({co, s} !== ref_v) begin
            failures++;
            $display("FAIL exhaustive %0d+%0d+%0d: got %0d required %0d", a, b, c, {co, s}, ref_v);
          end
        end
  endtask

  task automatic test_widths();
    int lat;
    b1.A = 1'b1; b1.B = 1'b1; b1.CIn = 1'b0; b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    lat = 1;
    while (!b1.done && lat < 10) begin tick(); lat++; end
    checks++;
    if (lat !== 2 || b1.Sum !== 1'b0 || b1.COut !== 1'b1) begin
      failures++;
      $display("FAIL w1_1_1_0: lat=%0d Sum=%b COut=%b required 2 0 1", lat, b1.Sum, b1.COut);
    end
    tick();
    b1.A = 1'b1; b1.B = 1'b0; b1.CIn = 1'b0; b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    lat = 1;
    while (!b1.done && lat < 10) begin tick(); lat++; end
    checks++;
    if (lat !== 2 || b1.Sum !== 1'b1 || b1.COut !== 1'b0) begin
      failures++;
      $display("FAIL w1_1_0_0: lat=%0d Sum=%b COut=%b required 2 1 0", lat, b1.Sum, b1.COut);
    end
    tick();
    b8.A = 8'd200; b8.B = 8'd100; b8.CIn = 1'b0; b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
    lat = 1;
    while (!b8.done && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat !== 9 || b8.Sum !== 8'd44 || b8.COut !== 1'b1) begin
      failures++;
      $display("FAIL w8_200_100: lat=%0d Sum=%0d COut=%b required 9 44 1", lat, b8.Sum, b8.COut);
    end
    tick();
  endtask

  initial begin
    b4.start = 1'b0; b4.A = '0; b4.B = '0; b4.CIn = 1'b0;
    b1.start = 1'b0; b1.A = '0; b1.B = '0; b1.CIn = 1'b0;
    b8.start = 1'b0; b8.A = '0; b8.B = '0; b8.CIn = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    test_hold();
    test_exhaustive();
    test_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
